// File: rtl/birthday_checker_if.sv
// Digit input and checker status bundle for birthday_checker.
interface birthday_checker_if;
    logic       id_valid;
    logic [3:0] id;
    logic       locked;
    logic       seq_done;
    logic       mismatch;
    logic [2:0] pos;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    modport master (
        output id_valid, id,
        input  locked, seq_done, mismatch, pos, frame_cnt, err_cnt
    );

    modport slave (
        input  id_valid, id,
        output locked, seq_done, mismatch, pos, frame_cnt, err_cnt
    );
endinterface

// File: rtl/birthday_checker.sv
// Tracks the 7-digit birthday sequence 0,9,3,1,F,2,E and
// reports lock, period completion, mismatches and saturating counts.
module birthday_checker (
    input  logic                      clk,
    input  logic                      reset,
    birthday_checker_if.slave         bus
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state;
    logic       locked;
    logic       seq_done;
    logic       mismatch;
    logic [2:0] pos;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    function automatic logic [3:0] seq_at(input logic [2:0] p);
        logic [3:0] d;
        case (p)
            3'd0:    d = 4'h0;
            3'd1:    d = 4'h9;
            3'd2:    d = 4'h3;
            3'd3:    d = 4'h1;
            3'd4:    d = 4'hF;
            3'd5:    d = 4'h2;
            3'd6:    d = 4'hE;
            default: d = 4'h0;
        endcase
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            locked    <= 1'b0;
            seq_done  <= 1'b0;
            mismatch  <= 1'b0;
            pos       <= 3'd0;
            frame_cnt <= 8'd0;
            err_cnt   <= 8'd0;
        end else begin
            seq_done <= 1'b0;
            mismatch <= 1'b0;
            if (bus.id_valid) begin
                case (state)
                    TRACK, LOCKED: begin
                        if (bus.id == seq_at(pos)) begin
                            if (pos == 3'd6) begin
                                pos      <= 3'd0;
                                seq_done <= 1'b1;
                                locked   <= 1'b1;
                                state    <= LOCKED;
                                if (frame_cnt != 8'hFF)
                                    frame_cnt <= frame_cnt + 8'd1;
                            end else begin
                                pos <= pos + 3'd1;
                            end
                        end else begin
                            mismatch <= 1'b1;
                            locked   <= 1'b0;
                            if (state == LOCKED && err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                            // A stray 0 may be the start of a fresh period
                            if (bus.id == 4'h0) begin
                                state <= TRACK;
                                pos   <= 3'd1;
                            end else begin
                                state <= HUNT;
                                pos   <= 3'd0;
                            end
                        end
                    end
                    default: begin
                        if (bus.id == 4'h0) begin
                            state <= TRACK;
                            pos   <= 3'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked;
    assign bus.seq_done  = seq_done;
    assign bus.mismatch  = mismatch;
    assign bus.pos       = pos;
    assign bus.frame_cnt = frame_cnt;
    assign bus.err_cnt   = err_cnt;

endmodule

// File: doc/birthday_checker.md
BIRTHDAY_CHECKER -- requirements
Module: birthday_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port: id_valid  input  1  qualifies id; when 0, id is ignored.
REQ-005 Port: id  input  4  received digit from the birthday sequence generator.
REQ-006 Port: locked  output  1  high while at least one full period has been received with no mismatch since.
REQ-007 Port: seq_done  output  1  one-cycle pulse when a full 7-digit period completes correctly.
REQ-008 Port: mismatch  output  1  one-cycle pulse when a tracked digit differs from the expected digit.
REQ-009 Port: pos  output  3  index (0..6) of the next expected digit.
REQ-010 Port: frame_cnt  output  8  count of completed periods; saturates at 255.
REQ-011 Port: err_cnt  output  8  count of mismatches while locked; saturates at 255.

Function
REQ-012 The expected sequence SHALL be, by index 0..6: 0x0, 0x9, 0x3, 0x1, 0xF, 0x2, 0xE, then repeat from index 0.
REQ-013 The block SHALL implement three states: HUNT, TRACK and LOCKED.
REQ-014 All outputs SHALL be registered.
- Every response appears in the cycle after the rising edge on which the digit is sampled (latency 1).
REQ-015 A cycle with id_valid=0 SHALL hold state, pos and both counters, and SHALL drive seq_done=0 and mismatch=0.
REQ-016 HUNT behaviour:
- pos=0.
- A valid 0x0 moves the block to TRACK with pos=1.
- Any other valid digit stays in HUNT and raises no mismatch.
REQ-017 TRACK/LOCKED match:
- A valid digit equal to seq[pos] advances pos by 1.
- pos wraps from 6 to 0.
REQ-018 Period completion:
- A match at pos=6 (digit 0xE) pulses seq_done and increments frame_cnt (saturating).
- It also enters LOCKED with locked=1 (stays LOCKED if already there).
REQ-019 Mismatch in TRACK or LOCKED:
- Pulses mismatch and sets locked=0.
- If the digit is 0x0, go to TRACK with pos=1 (immediate resync).
- Otherwise go to HUNT with pos=0.
REQ-020 err_cnt SHALL increment (saturating at 255) only on mismatches detected in LOCKED; TRACK mismatches SHALL not count.
REQ-021 seq_done and mismatch SHALL never be high in the same cycle.
REQ-022 Counters SHALL hold at 255 once saturated; they are cleared only by reset.

Reset
REQ-023 On reset, the block SHALL enter HUNT and drive pos=0, locked=0, seq_done=0, mismatch=0, frame_cnt=0 and err_cnt=0 in the following cycle.
REQ-024 Reset SHALL take priority over id_valid in the same cycle.
- A partially received period is discarded and does not count toward seq_done.

Verification
REQ-025 After reset, drive 0,9,3,1,F,2,E with id_valid=1 on every cycle -> seq_done pulses for one cycle, one cycle after E is sampled; locked=1; frame_cnt=1; pos=0.
REQ-026 From LOCKED, drive 0,9,3,5 -> mismatch pulses one cycle after 5; locked=0; err_cnt=1; pos=0.
REQ-027 Repeat the REQ-025 stimulus with 1-3 id_valid=0 cycles between digits -> same final values; no extra pulses; pos holds during gaps.
REQ-028 After reset, drive 0,9,0,9,3,1,F,2,E -> mismatch at the second 0 (err_cnt stays 0, pos=1); seq_done after E; frame_cnt=1.
REQ-029 Drive 0,9,3, assert reset for one cycle, then drive 1,F,2,E -> all outputs 0 after reset; no seq_done; pos stays 0.
REQ-030 Drive 260 consecutive correct periods -> frame_cnt=255; locked=1; err_cnt=0.
